// File: rtl/fan_run_sequencer.sv
// fan_run_sequencer: button-driven fan run/speed/timer-stage controller.
// Ports: clk, reset_p (sync, active-high); btn_speed/btn_timer/btn_off
//   one-cycle pulses; timer_value BCD count in. fan_run, speed, duty,
//   timer_load strobe, timer_preset, timer_led one-hot, timeout_evt out.
// Optional macro FAN_SOFT_START_EN: ramp duty upward one step per RAMP_DIV.
module fan_run_sequencer #(
    parameter logic [15:0] PRESET1  = 16'h0100,
    parameter logic [15:0] PRESET2  = 16'h0300,
    parameter logic [15:0] PRESET3  = 16'h0500,
    parameter logic [7:0]  DUTY1    = 8'd85,
    parameter logic [7:0]  DUTY2    = 8'd170,
    parameter logic [7:0]  DUTY3    = 8'd255,
    parameter int          RAMP_DIV = 1000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        btn_speed,
    input  logic        btn_timer,
    input  logic        btn_off,
    input  logic [15:0] timer_value,
    output logic        fan_run,
    output logic [1:0]  speed,
    output logic [7:0]  duty,
    output logic        timer_load,
    output logic [15:0] timer_preset,
    output logic [2:0]  timer_led,
    output logic        timeout_evt
);

    typedef enum logic [1:0] {
        OFF, RUN, TIMED, EXPIRE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  speed_q, speed_d;
    logic [1:0]  stage_q, stage_d;
    logic        armed_q, armed_d;
    logic        load_q, load_d;
    logic [15:0] preset_q, preset_d;
    logic        evt_q, evt_d;
    logic        run_q, run_d;
    logic [2:0]  led_q, led_d;
    logic [7:0]  duty_q, duty_d;
    logic [7:0]  tgt;
    logic [1:0]  speed_nx;
    logic        expire;

    assign speed_nx = (speed_q == 2'd3) ? 2'd1 : speed_q + 2'd1;
    assign expire   = (state_q == TIMED) && armed_q
                      && (timer_value == 16'h0000);

    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        stage_d  = stage_q;
        armed_d  = armed_q;
        load_d   = 1'b0;
        preset_d = preset_q;
        evt_d    = 1'b0;
        // The count has left zero, so a later zero is a real expiry.
        if (state_q == TIMED && timer_value != 16'h0000)
            armed_d = 1'b1;
        unique case (state_q)
            OFF: begin
                if (btn_speed) begin
                    state_d = RUN;
                    speed_d = 2'd1;
                end
            end
            RUN: begin
                if (btn_off) begin
                    state_d = OFF;
                    speed_d = 2'd0;
                    stage_d = 2'd0;
                end else if (btn_timer) begin
                    state_d  = TIMED;
                    stage_d  = 2'd1;
                    load_d   = 1'b1;
                    preset_d = PRESET1;
                    armed_d  = 1'b0;
                end else if (btn_speed) begin
                    speed_d = speed_nx;
                end
            end
            TIMED: begin
                if (btn_off) begin
                    state_d  = OFF;
                    speed_d  = 2'd0;
                    stage_d  = 2'd0;
                    load_d   = 1'b1;
                    preset_d = 16'h0000;
                    armed_d  = 1'b0;
                end else if (expire) begin
                    state_d = EXPIRE;
                    speed_d = 2'd0;
                    stage_d = 2'd0;
                    evt_d   = 1'b1;
                    armed_d = 1'b0;
                end else if (btn_timer) begin
                    load_d  = 1'b1;
                    armed_d = 1'b0;
                    case (stage_q)
                        2'd1: begin
                            stage_d  = 2'd2;
                            preset_d = PRESET2;
                        end
                        2'd2: begin
                            stage_d  = 2'd3;
                            preset_d = PRESET3;
                        end
                        default: begin
                            stage_d  = 2'd0;
                            preset_d = 16'h0000;
                            state_d  = RUN;
                        end
                    endcase
                end else if (btn_speed) begin
                    speed_d = speed_nx;
                end
            end
            EXPIRE: begin
                state_d = OFF;
                armed_d = 1'b0;
            end
            default: state_d = OFF;
        endcase
        run_d = (state_d == RUN) || (state_d == TIMED);
        unique case (stage_d)
            2'd1:    led_d = 3'b001;
            2'd2:    led_d = 3'b010;
            2'd3:    led_d = 3'b100;
            default: led_d = 3'b000;
        endcase
    end

    always_comb begin
        unique case (speed_q)
            2'd1:    tgt = DUTY1;
            2'd2:    tgt = DUTY2;
            2'd3:    tgt = DUTY3;
            default: tgt = 8'd0;
        endcase
    end

`ifdef FAN_SOFT_START_EN
    localparam int CW = $clog2(RAMP_DIV + 1);
    logic [CW-1:0] ramp_q, ramp_d;

    // Rises creep up from the present duty; falls jump at once.
    always_comb begin
        ramp_d = '0;
        duty_d = duty_q;
        if (tgt == 8'd0 || tgt < duty_q) begin
            duty_d = tgt;
        end else if (tgt > duty_q) begin
            if (ramp_q == CW'(RAMP_DIV - 1))
                duty_d = duty_q + 8'd1;
            else
                ramp_d = ramp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) ramp_q <= '0;
        else         ramp_q <= ramp_d;
    end
`else
    assign duty_d = tgt;
`endif

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q  <= OFF;
            speed_q  <= 2'd0;
            stage_q  <= 2'd0;
            armed_q  <= 1'b0;
            load_q   <= 1'b0;
            preset_q <= 16'h0000;
            evt_q    <= 1'b0;
            run_q    <= 1'b0;
            led_q    <= 3'b000;
            duty_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            stage_q  <= stage_d;
            armed_q  <= armed_d;
            load_q   <= load_d;
            preset_q <= preset_d;
            evt_q    <= evt_d;
            run_q    <= run_d;
            led_q    <= led_d;
            duty_q   <= duty_d;
        end
    end

    assign fan_run      = run_q;
    assign speed        = speed_q;
    assign duty         = duty_q;
    assign timer_load   = load_q;
    assign timer_preset = preset_q;
    assign timer_led    = led_q;
    assign timeout_evt  = evt_q;

endmodule

// File: tb/tb_fan_run_sequencer.sv
// tb_fan_run_sequencer: vector table plus hand sequences for
// fan_run_sequencer, expected outputs queued per driven cycle.
module tb_fan_run_sequencer;

    logic        clk = 1'b0;
    logic        reset_p;
    logic        btn_speed, btn_timer, btn_off;
    logic [15:0] timer_value;
    logic        fan_run;
    logic [1:0]  speed;
    logic [7:0]  duty;
    logic        timer_load;
    logic [15:0] timer_preset;
    logic [2:0]  timer_led;
    logic        timeout_evt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int rst, bs, bt, bo, tv;
        int fan, spd, duty, led, ld, pre, evt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    fan_run_sequencer #(.RAMP_DIV(2)) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .btn_speed   (btn_speed),
        .btn_timer   (btn_timer),
        .btn_off     (btn_off),
        .timer_value (timer_value),
        .fan_run     (fan_run),
        .speed       (speed),
        .duty        (duty),
        .timer_load  (timer_load),
        .timer_preset(timer_preset),
        .timer_led   (timer_led),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int rst, int bs, int bt, int bo, int tv,
                                int fan, int spd, int dt, int led,
                                int ld, int pre, int evt);
        vec_t v;
        v.rst = rst; v.bs = bs; v.bt = bt; v.bo = bo; v.tv = tv;
        v.fan = fan; v.spd = spd; v.duty = dt; v.led = led;
        v.ld = ld; v.pre = pre; v.evt = evt;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        vec_t e;
        reset_p     = 1'(v.rst);
        btn_speed   = 1'(v.bs);
        btn_timer   = 1'(v.bt);
        btn_off     = 1'(v.bo);
        timer_value = 16'(v.tv);
        sb.push_back(v);
        @(posedge clk);
        #1;
        btn_speed = 1'b0;
        btn_timer = 1'b0;
        btn_off   = 1'b0;
        e = sb.pop_front();
        chk({tag, ".fan"},  int'(fan_run),      e.fan);
        chk({tag, ".spd"},  int'(speed),        e.spd);
`ifndef FAN_SOFT_START_EN
        chk({tag, ".duty"}, int'(duty),         e.duty);
`endif
        chk({tag, ".led"},  int'(timer_led),    e.led);
        chk({tag, ".ld"},   int'(timer_load),   e.ld);
        chk({tag, ".pre"},  int'(timer_preset), e.pre);
        chk({tag, ".evt"},  int'(timeout_evt),  e.evt);
    endtask

    initial begin
        int cnt;
        reset_p = 1'b1;
        btn_speed = 1'b0;
        btn_timer = 1'b0;
        btn_off = 1'b0;
        timer_value = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.fan",  int'(fan_run),      0);
        chk("rst.spd",  int'(speed),        0);
        chk("rst.duty", int'(duty),         0);
        chk("rst.led",  int'(timer_led),    0);
        chk("rst.ld",   int'(timer_load),   0);
        chk("rst.pre",  int'(timer_preset), 0);
        chk("rst.evt",  int'(timeout_evt),  0);
        reset_p = 1'b0;

        // rst bs bt bo tv | fan spd duty led ld pre evt
        tbl.push_back(mk(0,1,0,0,'h0000, 1,1,  0,0,0,'h0000,0));
        tbl.push_back(mk(0,1,0,0,'h0000, 1,2, 85,0,0,'h0000,0));
        tbl.push_back(mk(0,1,0,0,'h0000, 1,3,170,0,0,'h0000,0));
        tbl.push_back(mk(0,1,0,0,'h0000, 1,1,255,0,0,'h0000,0));
        tbl.push_back(mk(0,0,0,0,'h0000, 1,1, 85,0,0,'h0000,0));
        tbl.push_back(mk(0,0,1,0,'h0000, 1,1, 85,1,1,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0000, 1,1, 85,1,0,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0000, 1,1, 85,1,0,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0000, 1,1, 85,1,0,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0100, 1,1, 85,1,0,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0059, 1,1, 85,1,0,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0001, 1,1, 85,1,0,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0000, 0,0, 85,0,0,'h0100,1));
        tbl.push_back(mk(0,0,0,0,'h0000, 0,0,  0,0,0,'h0100,0));
        tbl.push_back(mk(0,0,1,0,'h0000, 0,0,  0,0,0,'h0100,0));
        tbl.push_back(mk(0,0,0,1,'h0000, 0,0,  0,0,0,'h0100,0));
        tbl.push_back(mk(0,1,0,0,'h0000, 1,1,  0,0,0,'h0100,0));
        tbl.push_back(mk(0,0,1,0,'h0000, 1,1, 85,1,1,'h0100,0));
        tbl.push_back(mk(0,0,1,0,'h0000, 1,1, 85,2,1,'h0300,0));
        tbl.push_back(mk(0,0,1,0,'h0000, 1,1, 85,4,1,'h0500,0));
        tbl.push_back(mk(0,0,1,0,'h0000, 1,1, 85,0,1,'h0000,0));
        tbl.push_back(mk(0,0,0,0,'h0000, 1,1, 85,0,0,'h0000,0));
        tbl.push_back(mk(0,1,0,0,'h0000, 1,2, 85,0,0,'h0000,0));
        tbl.push_back(mk(0,0,1,0,'h0000, 1,2,170,1,1,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0100, 1,2,170,1,0,'h0100,0));
        tbl.push_back(mk(0,1,0,1,'h0000, 0,0,170,0,1,'h0000,0));
        tbl.push_back(mk(0,0,0,0,'h0000, 0,0,  0,0,0,'h0000,0));
        tbl.push_back(mk(0,1,0,0,'h0000, 1,1,  0,0,0,'h0000,0));
        tbl.push_back(mk(0,0,1,0,'h0000, 1,1, 85,1,1,'h0100,0));
        tbl.push_back(mk(0,0,0,0,'h0100, 1,1, 85,1,0,'h0100,0));
        tbl.push_back(mk(0,1,1,0,'h0000, 0,0, 85,0,0,'h0100,1));
        tbl.push_back(mk(0,0,0,0,'h0000, 0,0,  0,0,0,'h0100,0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // Reset while armed, with a timer press and a zero count pending.
        apply(mk(0,1,0,0,'h0000, 1,1,  0,0,0,'h0100,0), "h0");
        apply(mk(0,0,1,0,'h0000, 1,1, 85,1,1,'h0100,0), "h1");
        apply(mk(0,0,0,0,'h0100, 1,1, 85,1,0,'h0100,0), "h2");
        apply(mk(1,0,1,0,'h0000, 0,0,  0,0,0,'h0000,0), "h3");
        apply(mk(0,0,0,0,'h0000, 0,0,  0,0,0,'h0000,0), "h4");
        chk("h4.duty", int'(duty), 0);

`ifdef FAN_SOFT_START_EN
        btn_speed = 1'b1;
        @(posedge clk);
        #1;
        btn_speed = 1'b0;
        chk("ramp.spd", int'(speed), 1);
        cnt = 0;
        while (duty != 8'd85 && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("ramp.duty", int'(duty), 85);
        chk("ramp.len", cnt, 170);
        btn_off = 1'b1;
        @(posedge clk);
        #1;
        btn_off = 1'b0;
        @(posedge clk);
        #1;
        chk("ramp.off", int'(duty), 0);
        btn_speed = 1'b1;
        @(posedge clk);
        #1;
        btn_speed = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("mid.part", int'(duty > 8'd0 && duty < 8'd85), 1);
        btn_off = 1'b1;
        @(posedge clk);
        #1;
        btn_off = 1'b0;
        chk("mid.spd", int'(speed), 0);
        @(posedge clk);
        #1;
        chk("mid.duty", int'(duty), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
